// File: rtl/vga_timing_gen.sv
// VGA timing generator: divides the system clock down to a pixel rate and
// produces column/row counters with registered sync and visible-area flags.
module vga_timing_gen #(
    parameter int CLK_DIV     = 4,
    parameter int H_TOTAL     = 800,
    parameter int H_SYNC      = 96,
    parameter int H_VIS_START = 144,
    parameter int H_VIS_END   = 784,
    parameter int V_TOTAL     = 525,
    parameter int V_SYNC      = 2,
    parameter int V_VIS_START = 35,
    parameter int V_VIS_END   = 515
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    output logic [9:0] hCount,
    output logic [9:0] vCount,
    output logic       bright,
    output logic       hSync,
    output logic       vSync,
    output logic       pix_tick,
    output logic       frame_start
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       hCount_q, hCount_d;
    logic [9:0]       vCount_q, vCount_d;
    logic             bright_q, bright_d;
    logic             hSync_q, hSync_d;
    logic             vSync_q, vSync_d;
    logic             tick;

    // Next-state counters plus decode of the flags from those next values,
    // so the registered flags always line up with the counters they describe.
    always_comb begin
        div_d    = div_q;
        hCount_d = hCount_q;
        vCount_d = vCount_q;
        tick     = rst_n && en && (div_q == DIV_LAST);

        if (en) begin
            if (div_q == DIV_LAST) begin
                div_d = '0;
            end else begin
                div_d = div_q + DIV_W'(1);
            end
        end

        if (tick) begin
            if (hCount_q == H_LAST) begin
                hCount_d = '0;
                if (vCount_q == V_LAST) begin
                    vCount_d = '0;
                end else begin
                    vCount_d = vCount_q + 10'd1;
                end
            end else begin
                hCount_d = hCount_q + 10'd1;
            end
        end

        hSync_d  = (hCount_d >= 10'(H_SYNC));
        vSync_d  = (vCount_d >= 10'(V_SYNC));
        bright_d = (hCount_d >= 10'(H_VIS_START)) && (hCount_d < 10'(H_VIS_END)) &&
                   (vCount_d >= 10'(V_VIS_START)) && (vCount_d < 10'(V_VIS_END));
    end

    // State register; reset forces every counter and flag to zero at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q    <= '0;
            hCount_q <= '0;
            vCount_q <= '0;
            bright_q <= 1'b0;
            hSync_q  <= 1'b0;
            vSync_q  <= 1'b0;
        end else begin
            div_q    <= div_d;
            hCount_q <= hCount_d;
            vCount_q <= vCount_d;
            bright_q <= bright_d;
            hSync_q  <= hSync_d;
            vSync_q  <= vSync_d;
        end
    end

    assign hCount      = hCount_q;
    assign vCount      = vCount_q;
    assign bright      = bright_q;
    assign hSync       = hSync_q;
    assign vSync       = vSync_q;
    assign pix_tick    = tick;
    assign frame_start = tick && (hCount_q == H_LAST) && (vCount_q == V_LAST);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen using a shrunk screen geometry so a
// whole frame fits in a few thousand clocks.
module tb_vga_timing_gen;

    localparam int CLK_DIV     = 4;
    localparam int H_TOTAL     = 40;
    localparam int H_SYNC      = 6;
    localparam int H_VIS_START = 10;
    localparam int H_VIS_END   = 34;
    localparam int V_TOTAL     = 12;
    localparam int V_SYNC      = 2;
    localparam int V_VIS_START = 3;
    localparam int V_VIS_END   = 10;
    localparam int FRAME_CLKS  = CLK_DIV * H_TOTAL * V_TOTAL;

    logic       clk;
    logic       rstN;
    logic       en;
    logic [9:0] hCount;
    logic [9:0] vCount;
    logic       bright;
    logic       hSync;
    logic       vSync;
    logic       pixTick;
    logic       frameStart;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic en;
        int   nClk;
        int   h;
        int   v;
        logic bright;
        logic hSync;
        logic vSync;
        logic tick;
        logic frame;
    } vec_t;

    vec_t vecs[$];

    vga_timing_gen #(
        .CLK_DIV    (CLK_DIV),
        .H_TOTAL    (H_TOTAL),
        .H_SYNC     (H_SYNC),
        .H_VIS_START(H_VIS_START),
        .H_VIS_END  (H_VIS_END),
        .V_TOTAL    (V_TOTAL),
        .V_SYNC     (V_SYNC),
        .V_VIS_START(V_VIS_START),
        .V_VIS_END  (V_VIS_END)
    ) dut (
        .clk        (clk),
        .rst_n      (rstN),
        .en         (en),
        .hCount     (hCount),
        .vCount     (vCount),
        .bright     (bright),
        .hSync      (hSync),
        .vSync      (vSync),
        .pix_tick   (pixTick),
        .frame_start(frameStart)
    );

    // Free-running clock; rising edges at 5, 15, 25 ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Drive en, then let nClk rising edges pass; returns on a falling edge.
    task automatic applyStimulus(input logic enVal, input int nClk);
        en = enVal;
        repeat (nClk) @(negedge clk);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".hCount"}, 16'(hCount), 16'd0);
        checkOutput({tag, ".vCount"}, 16'(vCount), 16'd0);
        checkOutput({tag, ".bright"}, 16'(bright), 16'd0);
        checkOutput({tag, ".hSync"}, 16'(hSync), 16'd0);
        checkOutput({tag, ".vSync"}, 16'(vSync), 16'd0);
        checkOutput({tag, ".pix_tick"}, 16'(pixTick), 16'd0);
        checkOutput({tag, ".frame_start"}, 16'(frameStart), 16'd0);
    endtask

    task automatic doReset();
        en   = 1'b0;
        rstN = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int framePulses;
        int firstPulse;
        int pulseGap;
        int ticksBetween;
        int rangeErrs;
        int syncErrs;

        // Vectors: cumulative from reset release, every entry lists clocks to advance.
        //                 en    n    h   v  br hs vs tk fr
        vecs.push_back('{1'b1,   3,  0,  0, 0, 0, 0, 1, 0});
        vecs.push_back('{1'b1,   1,  1,  0, 0, 0, 0, 0, 0});
        vecs.push_back('{1'b1,  16,  5,  0, 0, 0, 0, 0, 0});
        vecs.push_back('{1'b1,   4,  6,  0, 0, 1, 0, 0, 0});
        vecs.push_back('{1'b1, 492,  9,  3, 0, 1, 1, 0, 0});
        vecs.push_back('{1'b1,   4, 10,  3, 1, 1, 1, 0, 0});
        vecs.push_back('{1'b1,  92, 33,  3, 1, 1, 1, 0, 0});
        vecs.push_back('{1'b1,   4, 34,  3, 0, 1, 1, 0, 0});
        vecs.push_back('{1'b1,  20, 39,  3, 0, 1, 1, 0, 0});
        vecs.push_back('{1'b1,   3, 39,  3, 0, 1, 1, 1, 0});
        vecs.push_back('{1'b1,   1,  0,  4, 0, 0, 1, 0, 0});
        vecs.push_back('{1'b1, 880, 20,  9, 1, 1, 1, 0, 0});
        vecs.push_back('{1'b1, 160, 20, 10, 0, 1, 1, 0, 0});
        vecs.push_back('{1'b1, 236, 39, 11, 0, 1, 1, 0, 0});
        vecs.push_back('{1'b1,   3, 39, 11, 0, 1, 1, 1, 1});
        vecs.push_back('{1'b1,   1,  0,  0, 0, 0, 0, 0, 0});
        vecs.push_back('{1'b1,   4,  1,  0, 0, 0, 0, 0, 0});
        vecs.push_back('{1'b1, 156,  0,  1, 0, 0, 0, 0, 0});
        vecs.push_back('{1'b1, 160,  0,  2, 0, 0, 1, 0, 0});
        vecs.push_back('{1'b1,   2,  0,  2, 0, 0, 1, 0, 0});
        vecs.push_back('{1'b0,  37,  0,  2, 0, 0, 1, 0, 0});
        vecs.push_back('{1'b1,   1,  0,  2, 0, 0, 1, 1, 0});
        vecs.push_back('{1'b1,   1,  1,  2, 0, 0, 1, 0, 0});

        // Reset state, including clocks with en high while reset is held.
        rstN = 1'b0;
        en   = 1'b0;
        @(negedge clk);
        checkAllZero("reset");
        en = 1'b1;
        repeat (3) @(negedge clk);
        checkAllZero("resetEn");

        // Table-driven run from reset release.
        rstN = 1'b1;
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].en, vecs[i].nClk);
            checkOutput($sformatf("v%0d.hCount", i), 16'(hCount), 16'(vecs[i].h));
            checkOutput($sformatf("v%0d.vCount", i), 16'(vCount), 16'(vecs[i].v));
            checkOutput($sformatf("v%0d.bright", i), 16'(bright), 16'(vecs[i].bright));
            checkOutput($sformatf("v%0d.hSync", i), 16'(hSync), 16'(vecs[i].hSync));
            checkOutput($sformatf("v%0d.vSync", i), 16'(vSync), 16'(vecs[i].vSync));
            checkOutput($sformatf("v%0d.pix_tick", i), 16'(pixTick), 16'(vecs[i].tick));
            checkOutput($sformatf("v%0d.frame_start", i), 16'(frameStart), 16'(vecs[i].frame));
        end

        // Asynchronous reset mid-frame, between clock edges, then a clean restart.
        applyStimulus(1'b1, 1203);
        checkOutput("preAsync.nonzero", 16'((hCount != 0) || (vCount != 0)), 16'd1);
        #2;
        rstN = 1'b0;
        #1;
        checkAllZero("asyncRst");
        @(negedge clk);
        checkAllZero("asyncHeld");
        rstN = 1'b1;
        applyStimulus(1'b1, 3);
        checkOutput("restart.tick", 16'(pixTick), 16'd1);
        checkOutput("restart.hBefore", 16'(hCount), 16'd0);
        applyStimulus(1'b1, 1);
        checkOutput("restart.hCount", 16'(hCount), 16'd1);
        checkOutput("restart.vCount", 16'(vCount), 16'd0);
        checkOutput("restart.hSync", 16'(hSync), 16'd0);
        checkOutput("restart.bright", 16'(bright), 16'd0);
        checkOutput("restart.tickAfter", 16'(pixTick), 16'd0);

        // Two full frames: frame pulse spacing, ticks per frame, range and sync decode.
        doReset();
        rstN         = 1'b1;
        en           = 1'b1;
        framePulses  = 0;
        firstPulse   = -1;
        pulseGap     = -1;
        ticksBetween = 0;
        rangeErrs    = 0;
        syncErrs     = 0;
        for (int k = 1; k <= 2 * FRAME_CLKS + 60; k++) begin
            @(negedge clk);
            if (framePulses == 1 && pixTick) ticksBetween++;
            if (frameStart) begin
                framePulses++;
                if (framePulses == 1) firstPulse = k;
                if (framePulses == 2) pulseGap = k - firstPulse;
            end
            if (hCount >= 10'(H_TOTAL) || vCount >= 10'(V_TOTAL)) rangeErrs++;
            if (vSync !== (vCount >= 10'(V_SYNC))) syncErrs++;
            if (hSync !== (hCount >= 10'(H_SYNC))) syncErrs++;
        end
        checkOutput("frame.pulses", 16'(framePulses), 16'd2);
        checkOutput("frame.firstAt", 16'(firstPulse), 16'(FRAME_CLKS - 1));
        checkOutput("frame.gap", 16'(pulseGap), 16'(FRAME_CLKS));
        checkOutput("frame.ticks", 16'(ticksBetween), 16'(H_TOTAL * V_TOTAL));
        checkOutput("frame.range", 16'(rangeErrs), 16'd0);
        checkOutput("frame.syncDecode", 16'(syncErrs), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 The block SHALL expose parameter CLK_DIV, default 4, meaning system clocks per pixel (100 MHz in, 25 MHz pixel rate).
REQ-002 The block SHALL expose parameters H_TOTAL 800, H_SYNC 96, H_VIS_START 144, H_VIS_END 784, meaning line length, hSync width, first visible column, first non-visible column.
REQ-003 The block SHALL expose parameters V_TOTAL 525, V_SYNC 2, V_VIS_START 35, V_VIS_END 515, meaning frame length, vSync width, first visible row, first non-visible row.
REQ-004 clk  input  1  system clock; all state changes occur on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 en  input  1  count enable; when low, all counters and outputs hold.
REQ-007 hCount  output  10  current column, 0..H_TOTAL-1.
REQ-008 vCount  output  10  current row, 0..V_TOTAL-1.
REQ-009 bright  output  1  high when (hCount, vCount) is inside the visible window.
REQ-010 hSync  output  1  horizontal sync, active-low.
REQ-011 vSync  output  1  vertical sync, active-low.
REQ-012 pix_tick  output  1  one-clk pulse on the clk where hCount advances.
REQ-013 frame_start  output  1  one-clk pulse when hCount and vCount both wrap to 0.

Function
REQ-014 A divider counter SHALL count 0..CLK_DIV-1 while en=1 and assert pix_tick for the clk in which it equals CLK_DIV-1.
REQ-015 On pix_tick, hCount SHALL increment; at H_TOTAL-1 it SHALL wrap to 0 and vCount SHALL advance on that same edge.
REQ-016 vCount SHALL increment only on an hCount wrap; at V_TOTAL-1 it SHALL wrap to 0 on that same edge.
REQ-017 bright, hSync, vSync SHALL be registered and decoded from the next-state counter values, so all are cycle-aligned with the hCount/vCount they describe (zero relative latency).
REQ-018 hSync SHALL be 0 when hCount < H_SYNC, else 1.
REQ-019 vSync SHALL be 0 when vCount < V_SYNC, else 1.
REQ-020 bright SHALL be 1 when H_VIS_START <= hCount < H_VIS_END and V_VIS_START <= vCount < V_VIS_END, else 0.
REQ-021 frame_start SHALL pulse in the same clk as the pix_tick that moves (799,524) to (0,0).
REQ-022 When en=0, the divider, counters, and all outputs SHALL hold; pix_tick and frame_start SHALL be 0.
REQ-023 On en re-assertion, counting SHALL resume from the held divider value, with no skipped or repeated pixel.
REQ-024 Counter arithmetic SHALL be 10-bit unsigned; values >= H_TOTAL or >= V_TOTAL SHALL never appear on hCount or vCount.
REQ-025 Each frame SHALL contain exactly H_TOTAL*V_TOTAL pix_tick pulses (420000 at defaults).

Reset
REQ-026 While rst_n=0, regardless of clk: divider=0, hCount=0, vCount=0, bright=0, hSync=0, vSync=0, pix_tick=0, frame_start=0.
REQ-027 Assertion of rst_n mid-line or mid-frame SHALL abort the frame immediately; no partial state SHALL survive.
REQ-028 After rst_n deasserts, the first pix_tick SHALL occur CLK_DIV clks later and SHALL move hCount to 1.

Verification
REQ-029 Reset then en=1 for 4 clks -> pix_tick exactly once, on clk 4; hCount=1, vCount=0, hSync=0, bright=0.
REQ-030 Run to hCount=95 then 96 -> hSync 0 at 95, 1 at 96; bright 0 at hCount=143, 1 at 144 with vCount=35, 0 at 784.
REQ-031 Run a full line -> hCount wraps 799->0 and vCount 0->1 on the same clk; 3200 clks per line.
REQ-032 Run a full frame -> frame_start pulses once at (799,524)->(0,0), 1,680,000 clks apart; vSync low only for vCount 0..1.
REQ-033 Hold en=0 for 37 clks at hCount=300 mid-divider -> all outputs frozen, no pix_tick; after en=1, next tick gives hCount=301 at the expected residual count.
REQ-034 Pulse rst_n low asynchronously at (500,200) between clk edges -> all outputs 0 immediately; restart identical to REQ-029.
